// File: rtl/zx8302_pkg.sv
// rtl/zx8302_pkg.sv - shared constants and helpers for the ZX8302 interrupt controller
package zx8302_pkg;

    // Widest source vector the register file supports (one byte lane).
    localparam int MAX_N_SRC = 8;

    // Register indices on cpu_addr.
    localparam logic [1:0] ADDR_PENDING  = 2'd0;
    localparam logic [1:0] ADDR_MASK     = 2'd1;
    localparam logic [1:0] ADDR_MODE     = 2'd2;
    localparam logic [1:0] ADDR_OVERFLOW = 2'd3;

    // Per-source detection mode as stored in the mode register.
    typedef enum logic {
        MODE_EDGE  = 1'b0,
        MODE_LEVEL = 1'b1
    } src_mode_e;

    // Larger of two 68k priority levels.
    function automatic logic [2:0] ipl_max(input logic [2:0] a, input logic [2:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - single-bit multi-stage input synchroniser
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/zx8302_irq_ctrl.sv
// rtl/zx8302_irq_ctrl.sv - ZX8302 interrupt controller with pending/mask/mode/overflow registers and IPL merge
module zx8302_irq_ctrl
    import zx8302_pkg::*;
#(
    parameter int N_SRC       = 5,
    parameter int IRQ_LEVEL   = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cen,
    input  logic [N_SRC-1:0] src,
    input  logic [2:0]       ext_ipl_n,
    output logic [2:0]       ipl_n,
    output logic             irq,
    input  logic             cpu_sel,
    input  logic             cpu_wr,
    input  logic             cpu_lds,
    input  logic [1:0]       cpu_addr,
    input  logic [7:0]       cpu_din,
    output logic [7:0]       cpu_dout
);

    // Registers are kept a full byte wide; bits at or above N_SRC are forced
    // to zero by this mask so they read 0 and ignore writes.
    localparam logic [MAX_N_SRC-1:0] VALID = MAX_N_SRC'((1 << N_SRC) - 1);

    logic [MAX_N_SRC-1:0] sync_s;
    logic [MAX_N_SRC-1:0] hist_q,     hist_d;
    logic [MAX_N_SRC-1:0] pending_q,  pending_d;
    logic [MAX_N_SRC-1:0] overflow_q, overflow_d;
    logic [MAX_N_SRC-1:0] mask_q,     mask_d;
    logic [MAX_N_SRC-1:0] mode_q,     mode_d;
    logic [MAX_N_SRC-1:0] set_ev;
    logic [MAX_N_SRC-1:0] pend_clr;
    logic [MAX_N_SRC-1:0] ovf_clr;
    logic [SYNC_STAGES:0] arm_q,      arm_d;
    logic                 armed;
    logic                 wr_en;
    logic                 irq_q,      irq_d;
    logic [2:0]           ipl_n_q,    ipl_n_d;
    logic [2:0]           lvl_int;

    // One synchroniser per implemented source; unused lanes tie to zero.
    for (genvar i = 0; i < MAX_N_SRC; i++) begin : g_src
        if (i < N_SRC) begin : g_sync
            sync_ff #(
                .STAGES(SYNC_STAGES)
            ) u_sync (
                .clk    (clk),
                .reset_n(reset_n),
                .d      (src[i]),
                .q      (sync_s[i])
            );
        end else begin : g_tie
            assign sync_s[i] = 1'b0;
        end
    end

    // Release-side reset synchroniser: detection is armed only once the
    // source synchronisers and history flops have refilled after reset, so a
    // source held high through reset does not look like a rising edge.
    assign arm_d = {arm_q[SYNC_STAGES-1:0], 1'b1};
    assign armed = arm_q[SYNC_STAGES];

    // CPU write strobe and the per-register write-1-to-clear vectors.
    assign wr_en    = cpu_sel & cpu_wr & cpu_lds & cen;
    assign pend_clr = (wr_en && cpu_addr == ADDR_PENDING)  ? (cpu_din & VALID) : '0;
    assign ovf_clr  = (wr_en && cpu_addr == ADDR_OVERFLOW) ? (cpu_din & VALID) : '0;

    // Per-source set events: rising edge in edge mode, high level in level mode.
    always_comb begin
        set_ev = '0;
        for (int i = 0; i < MAX_N_SRC; i++) begin
            if (src_mode_e'(mode_q[i]) == MODE_LEVEL) begin
                set_ev[i] = sync_s[i];
            end else begin
                set_ev[i] = sync_s[i] & ~hist_q[i];
            end
        end
        set_ev = set_ev & VALID & {MAX_N_SRC{armed}};
    end

    // Register next-state: set beats clear, overflow records a set on a
    // bit that is already pending, history always follows the synchroniser.
    always_comb begin
        hist_d     = sync_s & VALID;
        pending_d  = (pending_q & ~pend_clr) | set_ev;
        overflow_d = (overflow_q & ~ovf_clr) | (set_ev & pending_q);
        mask_d     = mask_q;
        mode_d     = mode_q;
        if (wr_en && cpu_addr == ADDR_MASK) begin
            mask_d = cpu_din & VALID;
        end
        if (wr_en && cpu_addr == ADDR_MODE) begin
            mode_d = cpu_din & VALID;
        end
    end

    // Interrupt output and merged priority level.
    always_comb begin
        irq_d   = |(pending_q & mask_q);
        lvl_int = irq_q ? 3'(IRQ_LEVEL) : 3'd0;
        ipl_n_d = ~ipl_max(lvl_int, ~ext_ipl_n);
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            arm_q      <= '0;
            hist_q     <= '0;
            pending_q  <= '0;
            overflow_q <= '0;
            mask_q     <= '0;
            mode_q     <= '0;
            irq_q      <= 1'b0;
            ipl_n_q    <= 3'b111;
        end else begin
            arm_q      <= arm_d;
            hist_q     <= hist_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            mask_q     <= mask_d;
            mode_q     <= mode_d;
            irq_q      <= irq_d;
            ipl_n_q    <= ipl_n_d;
        end
    end

    // Combinational register read mux.
    always_comb begin
        cpu_dout = '0;
        case (cpu_addr)
            ADDR_PENDING:  cpu_dout = pending_q;
            ADDR_MASK:     cpu_dout = mask_q;
            ADDR_MODE:     cpu_dout = mode_q;
            ADDR_OVERFLOW: cpu_dout = overflow_q;
            default:       cpu_dout = '0;
        endcase
    end

    assign irq   = irq_q;
    assign ipl_n = ipl_n_q;

endmodule

// File: doc/zx8302_irq_ctrl.md
ZX8302_IRQ_CTRL -- requirements
Module: zx8302_irq_ctrl

Interface
REQ-001 SHALL have parameter N_SRC, default 5, giving the number of interrupt sources (legal range 1..8).
REQ-002 SHALL have parameter IRQ_LEVEL, default 2, giving the 68k priority level raised by any enabled pending source (legal range 1..7).
REQ-003 SHALL have parameter SYNC_STAGES, default 2, giving the input synchroniser depth (legal range 2..3).
REQ-004 SHALL have ports:
- clk  in  1  single clock; all state on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cen  in  1  bus clock-enable; register writes take effect only when cen=1.
- src  in  N_SRC  raw interrupt request inputs, asynchronous to clk.
- ext_ipl_n  in  3  active-low IPL from the IPC.
- ipl_n  out  3  active-low merged IPL to the CPU.
- irq  out  1  high when any source is both pending and enabled.
- cpu_sel  in  1  register block selected.
- cpu_wr  in  1  write strobe.
- cpu_lds  in  1  low data strobe; only the low byte is used.
- cpu_addr  in  2  register index.
- cpu_din  in  8  write data.
- cpu_dout  out  8  read data, combinational on cpu_addr.

Function
REQ-005 SHALL pass each src bit through SYNC_STAGES flops and then one history flop; all detection SHALL use synchronised values only.
REQ-006 Per source, mode bit 0 (edge) SHALL set pending on a synchronised 0->1 transition; mode bit 1 (level) SHALL set pending on every clk while the synchronised src is 1.
REQ-007 Pending SHALL be set regardless of mask; mask SHALL gate only irq and ipl_n.
REQ-008 The register map SHALL be:
- addr 0: read pending; write-1-to-clear.
- addr 1: mask, read/write.
- addr 2: mode, read/write.
- addr 3: read overflow; write-1-to-clear.
REQ-009 Bits at or above N_SRC SHALL read 0 and ignore writes.
REQ-010 A write SHALL occur when cpu_sel, cpu_wr, cpu_lds and cen are all 1 on a clk edge; any other combination SHALL leave all registers unchanged.
REQ-011 If a set event and a write-1 clear hit the same bit on the same clk, set SHALL win and pending SHALL remain 1.
REQ-012 A set event on an already-pending bit SHALL set that bit's overflow flag; overflow SHALL be sticky until cleared via addr 3.
REQ-013 If an overflow set and a clear hit the same bit on the same clk, set SHALL win.
REQ-014 In level mode, a clear while src is still high SHALL be ineffective, because set wins.
REQ-015 irq SHALL be registered: irq = OR(pending & mask), visible one clk after pending changes.
REQ-016 ipl_n SHALL be registered: internal level L = IRQ_LEVEL if irq else 0; external level E = ~ext_ipl_n; ipl_n = ~max(L,E).
REQ-017 Latency from src rising (meeting setup) to irq=1 SHALL be SYNC_STAGES+2 clk edges, and to ipl_n valid SHALL be SYNC_STAGES+3 clk edges.
REQ-018 A mask write unmasking an already-pending bit SHALL raise irq on the next clk; masking SHALL lower irq on the next clk.
REQ-019 Changing a bit's mode SHALL NOT itself set pending; the history flop SHALL keep updating in both modes so that no spurious edge occurs on a mode switch.

Reset
REQ-020 While reset_n=0, sync and history flops, pending, overflow, mask and mode SHALL be 0, irq SHALL be 0, and ipl_n SHALL be 3'b111.
REQ-021 Deassertion of reset_n SHALL be synchronised internally; the first set event SHALL be possible no earlier than SYNC_STAGES+1 clk after release.
REQ-022 A src held high through reset SHALL NOT produce an edge-mode pending after release.

Structure
REQ-023 Register address constants, the mode encoding and the max-N_SRC constant SHALL live in the shared package zx8302_pkg.
REQ-024 The per-bit synchroniser SHALL be the single sub-module sync_ff, instantiated N_SRC times and parametrised by SYNC_STAGES.
REQ-025 No asynchronous set or reset SHALL be driven by data signals; every flop SHALL use clk and reset_n only.

Verification
REQ-026 Bench SHALL cover each of the following directed scenarios:
- N_SRC=5, mask=0x08, mode=0, pulse src[3] for 1 clk held over a sampling edge -> pending=0x08 after 3 clk, irq=1 after 4 clk, ipl_n=3'b101 after 5 clk; write 0x08 to addr 0 -> pending=0x00, ipl_n=3'b111 two clk later.
- Two rising edges on src[0] with no ack in between -> pending[0]=1 and overflow=0x01; write 0x01 to addr 3 -> overflow=0x00, pending unchanged.
- Level mode on src[1] held high, write-1 clear to addr 0 -> pending[1] stays 1; drop src[1] then clear -> pending[1]=0.
- Clear write and edge set on the same clk -> pending bit remains 1.
- ext_ipl_n=3'b010 (level 5) with internal irq active at IRQ_LEVEL=2 -> ipl_n=3'b010; drop ext to 3'b111 -> ipl_n=3'b101.
- reset_n pulsed low mid-operation with pending=0x1F -> all registers 0 and ipl_n=3'b111 immediately; src high across reset, edge mode -> no pending after release; write with cen=0 -> mask unchanged.
